mc_control: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the 2-bit `aluop` consumed by the ALU control decoder, plus all datapath strobes and mux selects. It sits between the instruction register opcode field, the unified memory port handshake and the branch unit.

---
 rtl/mc_control_pkg.sv | 60 ++++++
 rtl/mc_control.sv | 163 ++++++++++++++++
 tb/tb_mc_control.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multi-cycle RV32I main control FSM.
package mc_control_pkg;

  // ALU control decoder selector; encodings are fixed by the ALU control block.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2,
    SRCA_ZERO  = 2'd3
  } alusrc_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alusrc_b_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_UIMM     = 4'd4,
    S_ALUWB    = 4'd5,
    S_MEMADDR  = 4'd6,
    S_MEMREAD  = 4'd7,
    S_LOADWB   = 4'd8,
    S_MEMWRITE = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd13
  } ctrl_state_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath strobes, mux selects and the 2-bit ALU op.
module mc_control
  import mc_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output alusrc_a_t   alusrc_a,
  output alusrc_b_t   alusrc_b,
  output aluop_t      aluop,
  output logic        rf_we,
  output wb_sel_t     wb_sel,
  output logic        illegal,
  output ctrl_state_t state_o
);

  ctrl_state_t state_q, state_d;
  logic        illegal_q, illegal_d;

  // Raw strobes before reset gating.
  logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c;

  // State and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore outputs, plus the FETCH/BRANCH Mealy strobes.
  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    iord      = 1'b0;
    pc_sel    = 1'b0;
    alusrc_a  = SRCA_PC;
    alusrc_b  = SRCB_RS2;
    aluop     = ALUOP_ADD;
    wb_sel    = WB_ALUOUT;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrc_b  = SRCB_FOUR;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOUT captures OLDPC+IMM, the branch/JAL target.
        alusrc_a = SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        case (opcode)
          OPCODE_OP:                   state_d = S_EXEC_R;
          OPCODE_OP_IMM:               state_d = S_EXEC_I;
          OPCODE_LOAD, OPCODE_STORE:   state_d = S_MEMADDR;
          OPCODE_BRANCH:               state_d = S_BRANCH;
          OPCODE_JAL:                  state_d = S_JAL;
          OPCODE_JALR:                 state_d = S_JALR;
          OPCODE_LUI, OPCODE_AUIPC:    state_d = S_UIMM;
          OPCODE_FENCE, OPCODE_SYSTEM: state_d = S_FETCH;
          default:                     state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alusrc_a = SRCA_RS1;
        aluop    = ALUOP_RTYPE;
        state_d  = S_ALUWB;
      end
      S_EXEC_I: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = SRCB_IMM;
        aluop    = ALUOP_ITYPE;
        state_d  = S_ALUWB;
      end
      S_UIMM: begin
        alusrc_a = (opcode == OPCODE_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_c = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADDR: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = SRCB_IMM;
        state_d  = (opcode == OPCODE_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_LOADWB;
      end
      S_LOADWB: begin
        rf_we_c = 1'b1;
        wb_sel  = WB_MDR;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a = SRCA_RS1;
        aluop    = ALUOP_SUB;
        pc_we_c  = branch_taken;
        pc_sel   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        rf_we_c = 1'b1;
        wb_sel  = WB_PC;
        pc_we_c = 1'b1;
        pc_sel  = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = SRCB_IMM;
        rf_we_c  = 1'b1;
        wb_sel   = WB_PC;
        pc_we_c  = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Write and request strobes are suppressed for the whole reset cycle.
  assign mem_req = mem_req_c & ~rst;
  assign mem_we  = mem_we_c  & ~rst;
  assign ir_we   = ir_we_c   & ~rst;
  assign pc_we   = pc_we_c   & ~rst;
  assign rf_we   = rf_we_c   & ~rst;
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control.
module tb_mc_control;
  import mc_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, pc_sel, rf_we, illegal;
  alusrc_a_t   alusrc_a;
  alusrc_b_t   alusrc_b;
  aluop_t      aluop;
  wb_sel_t     wb_sel;
  ctrl_state_t state_o;

  typedef struct packed {
    ctrl_state_t st;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    alusrc_a_t   a;
    alusrc_b_t   b;
    aluop_t      op;
    logic        rf_we;
    wb_sel_t     wb;
    logic        ill;
  } obs_t;

  obs_t   exp_q[$];
  string  tag_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  mc_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alusrc_a     (alusrc_a),
    .alusrc_b     (alusrc_b),
    .aluop        (aluop),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Idle expectation for a state: every strobe 0, every select at its first value.
  function automatic obs_t base(ctrl_state_t s, logic ill);
    obs_t e;
    e     = '0;
    e.st  = s;
    e.a   = SRCA_PC;
    e.b   = SRCB_RS2;
    e.op  = ALUOP_ADD;
    e.wb  = WB_ALUOUT;
    e.ill = ill;
    return e;
  endfunction

  function automatic obs_t fetch(logic ready);
    obs_t e;
    e         = base(S_FETCH, 1'b0);
    e.mem_req = 1'b1;
    e.b       = SRCB_FOUR;
    e.ir_we   = ready;
    e.pc_we   = ready;
    return e;
  endfunction

  function automatic obs_t decode();
    obs_t e;
    e   = base(S_DECODE, 1'b0);
    e.a = SRCA_OLDPC;
    e.b = SRCB_IMM;
    return e;
  endfunction

  // Push the expectation, check it mid-cycle, then advance one clock.
  task automatic step(input string tag, input obs_t e);
    obs_t o, x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o = '{state_o, mem_req, mem_we, iord, ir_we, pc_we, pc_sel,
          alusrc_a, alusrc_b, aluop, rf_we, wb_sel, illegal};
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, o, x);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t e;
    logic [4:0] strobes;
    rst          = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b0;
    opcode       = OPCODE_OP;

    // Reset cycle 1: state unknown, strobes must still be low.
    @(negedge clk);
    strobes = {mem_req, mem_we, ir_we, pc_we, rf_we};
    n_cmp++;
    assert (strobes === 5'b0) else begin
      n_bad++;
      $error("FAIL rst_strobes: observed %b expected 00000", strobes);
    end
    @(posedge clk);
    #1;
    e = fetch(1'b0); e.ir_we = 1'b0; e.mem_req = 1'b0;
    step("rst_fetch", e);
    rst = 1'b0;

    // R-type, zero wait: 4 cycles.
    opcode = OPCODE_OP;
    step("r_fetch", fetch(1'b1));
    step("r_decode", decode());
    e = base(S_EXEC_R, 1'b0); e.a = SRCA_RS1; e.op = ALUOP_RTYPE;
    step("r_exec", e);
    e = base(S_ALUWB, 1'b0); e.rf_we = 1'b1;
    step("r_wb", e);

    // Load with three wait cycles in MEMREAD: 8 cycles.
    opcode = OPCODE_LOAD;
    step("ld_fetch", fetch(1'b1));
    step("ld_decode", decode());
    e = base(S_MEMADDR, 1'b0); e.a = SRCA_RS1; e.b = SRCB_IMM;
    step("ld_addr", e);
    mem_ready = 1'b0;
    e = base(S_MEMREAD, 1'b0); e.mem_req = 1'b1; e.iord = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step("ld_wait", e);
    mem_ready = 1'b1;
    step("ld_read", e);
    e = base(S_LOADWB, 1'b0); e.rf_we = 1'b1; e.wb = WB_MDR;
    step("ld_wb", e);

    // Store with one wait cycle in FETCH.
    opcode    = OPCODE_STORE;
    mem_ready = 1'b0;
    step("st_fetch_wait", fetch(1'b0));
    mem_ready = 1'b1;
    step("st_fetch", fetch(1'b1));
    step("st_decode", decode());
    e = base(S_MEMADDR, 1'b0); e.a = SRCA_RS1; e.b = SRCB_IMM;
    step("st_addr", e);
    e = base(S_MEMWRITE, 1'b0); e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
    step("st_write", e);

    // Branch not taken, then taken.
    opcode = OPCODE_BRANCH;
    for (int unsigned i = 0; i < 2; i++) begin
      branch_taken = (i == 1);
      step("br_fetch", fetch(1'b1));
      step("br_decode", decode());
      e = base(S_BRANCH, 1'b0); e.a = SRCA_RS1; e.op = ALUOP_SUB;
      e.pc_sel = 1'b1; e.pc_we = (i == 1);
      step(i == 1 ? "br_taken" : "br_not_taken", e);
    end
    branch_taken = 1'b0;

    // JAL and JALR.
    opcode = OPCODE_JAL;
    step("jal_fetch", fetch(1'b1));
    step("jal_decode", decode());
    e = base(S_JAL, 1'b0); e.rf_we = 1'b1; e.wb = WB_PC; e.pc_we = 1'b1; e.pc_sel = 1'b1;
    step("jal", e);
    opcode = OPCODE_JALR;
    step("jalr_fetch", fetch(1'b1));
    step("jalr_decode", decode());
    e = base(S_JALR, 1'b0); e.a = SRCA_RS1; e.b = SRCB_IMM;
    e.rf_we = 1'b1; e.wb = WB_PC; e.pc_we = 1'b1;
    step("jalr", e);

    // OP-IMM, LUI, AUIPC.
    opcode = OPCODE_OP_IMM;
    step("i_fetch", fetch(1'b1));
    step("i_decode", decode());
    e = base(S_EXEC_I, 1'b0); e.a = SRCA_RS1; e.b = SRCB_IMM; e.op = ALUOP_ITYPE;
    step("i_exec", e);
    e = base(S_ALUWB, 1'b0); e.rf_we = 1'b1;
    step("i_wb", e);
    opcode = OPCODE_LUI;
    step("lui_fetch", fetch(1'b1));
    step("lui_decode", decode());
    e = base(S_UIMM, 1'b0); e.a = SRCA_ZERO; e.b = SRCB_IMM;
    step("lui", e);
    e = base(S_ALUWB, 1'b0); e.rf_we = 1'b1;
    step("lui_wb", e);
    opcode = OPCODE_AUIPC;
    step("auipc_fetch", fetch(1'b1));
    step("auipc_decode", decode());
    e = base(S_UIMM, 1'b0); e.a = SRCA_OLDPC; e.b = SRCB_IMM;
    step("auipc", e);
    e = base(S_ALUWB, 1'b0); e.rf_we = 1'b1;
    step("auipc_wb", e);

    // FENCE is a 2-cycle NOP.
    opcode = OPCODE_FENCE;
    step("fence_fetch", fetch(1'b1));
    step("fence_decode", decode());

    // Reset in the middle of a load read aborts without a request.
    opcode = OPCODE_LOAD;
    step("ab_fetch", fetch(1'b1));
    step("ab_decode", decode());
    e = base(S_MEMADDR, 1'b0); e.a = SRCA_RS1; e.b = SRCB_IMM;
    step("ab_addr", e);
    rst = 1'b1;
    e = base(S_MEMREAD, 1'b0); e.iord = 1'b1;
    step("ab_rst", e);
    rst = 1'b0;
    step("ab_refetch", fetch(1'b1));

    // Illegal opcode traps until reset.
    opcode = 7'b0000000;
    step("il_decode", decode());
    for (int unsigned i = 0; i < 10; i++) step("il_trap", base(S_TRAP, 1'b1));
    rst = 1'b1;
    step("il_rst", base(S_TRAP, 1'b1));
    rst = 1'b0;
    step("il_after", fetch(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
